act_stream_pipe: RTL

Streaming, fully pipelined activation stage for the PE core vector datapath. It accepts LANES signed fixed-point elements per beat over a valid/ready handshake. Each lane gets one of six hard-approximated activation functions: GELU, ReLU, Swish, Sigmoid, Tanh and LeakyReLU. The activation selector travels with each beat, so the mode can change on every beat without draining the pipeline. The block sits between the PE accumulator output and the writeback buffer.

---
 rtl/act_stream_pipe.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/act_stream_pipe.sv
// Three-stage streaming activation pipe (GELU/ReLU/Swish/Sigmoid/Tanh/LeakyReLU) over LANES fixed-point lanes.
// Optional beat/clip statistics are built only when ACT_STATS_EN is defined; otherwise stat outputs read 0.
module act_stream_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int LANES      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_act_type,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [31:0]                 stat_beats,
  output logic [31:0]                 stat_clips
);

  localparam int DW = DATA_WIDTH;
  localparam int GW = DATA_WIDTH + 3;
  localparam int PW = 2 * DATA_WIDTH + 2;
  localparam int LW = LANES * DATA_WIDTH;

  localparam logic [2:0] ACT_GELU    = 3'd0;
  localparam logic [2:0] ACT_RELU    = 3'd1;
  localparam logic [2:0] ACT_SWISH   = 3'd2;
  localparam logic [2:0] ACT_SIGMOID = 3'd3;
  localparam logic [2:0] ACT_TANH    = 3'd4;
  localparam logic [2:0] ACT_LEAKY   = 3'd5;

  localparam logic signed [GW-1:0] G_ZERO    = GW'(32'sd0);
  localparam logic signed [GW-1:0] G_ONE     = GW'(32'sd1 <<< FRAC_BITS);
  localparam logic signed [GW-1:0] G_HALF    = G_ONE >>> 1;
  localparam logic signed [GW-1:0] G_NEG_ONE = -G_ONE;
  localparam logic signed [DW-1:0] D_ZERO    = DW'(32'sd0);
  localparam logic signed [PW-1:0] P_ROUND   = PW'(64'sd1 <<< (FRAC_BITS - 1));
  localparam logic signed [PW-1:0] P_MAX     = PW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] P_MIN     = PW'(-(64'sd1 <<< (DW - 1)));

  logic          advance_s;
  logic          s1_valid_r, s2_valid_r, s3_valid_r;
  logic [2:0]    s1_type_r, s2_type_r;
  logic [LW-1:0] s1_data_r, s2_x_r, s2_g_r, s2_t_r, s3_data_r;

  logic signed [GW-1:0] x_ext_s    [LANES];
  logic signed [GW-1:0] g_pre_s    [LANES];
  logic signed [DW-1:0] x2_s       [LANES];
  logic signed [DW-1:0] g2_s       [LANES];
  logic signed [PW-1:0] prod_s     [LANES];
  logic signed [PW-1:0] res_wide_s [LANES];
  logic [LW-1:0]        gate_s, tanh_s, res_s;

  // Global stall: every stage moves only when the output slot is free or being drained
  assign advance_s = !s3_valid_r || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = s3_valid_r;
  assign out_data  = s3_data_r;

  // Gate and tanh evaluation on the S1 operand, clamped before entering S2
  always_comb begin
    gate_s = {LW{1'b0}};
    tanh_s = {LW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      x_ext_s[i] = GW'($signed(s1_data_r[i*DW +: DW]));
      if (s1_type_r == ACT_GELU) begin
        g_pre_s[i] = (x_ext_s[i] >>> 2) + (x_ext_s[i] >>> 3) + (x_ext_s[i] >>> 4) + G_HALF;
      end else begin
        g_pre_s[i] = (x_ext_s[i] >>> 2) + G_HALF;
      end
      if (g_pre_s[i] < G_ZERO) begin
        gate_s[i*DW +: DW] = DW'(G_ZERO);
      end else if (g_pre_s[i] > G_ONE) begin
        gate_s[i*DW +: DW] = DW'(G_ONE);
      end else begin
        gate_s[i*DW +: DW] = DW'(g_pre_s[i]);
      end
      if (x_ext_s[i] > G_ONE) begin
        tanh_s[i*DW +: DW] = DW'(G_ONE);
      end else if (x_ext_s[i] < G_NEG_ONE) begin
        tanh_s[i*DW +: DW] = DW'(G_NEG_ONE);
      end else begin
        tanh_s[i*DW +: DW] = DW'(x_ext_s[i]);
      end
    end
  end

  // Final per-type result from S2 operands, saturated to the element range
  always_comb begin
    res_s = {LW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      x2_s[i]   = $signed(s2_x_r[i*DW +: DW]);
      g2_s[i]   = $signed(s2_g_r[i*DW +: DW]);
      prod_s[i] = PW'(x2_s[i]) * PW'(g2_s[i]);
      case (s2_type_r)
        ACT_RELU:           res_wide_s[i] = (x2_s[i] > D_ZERO) ? PW'(x2_s[i]) : PW'(D_ZERO);
        ACT_LEAKY:          res_wide_s[i] = (x2_s[i] > D_ZERO) ? PW'(x2_s[i]) : PW'(x2_s[i] >>> 3);
        ACT_SIGMOID:        res_wide_s[i] = PW'(g2_s[i]);
        ACT_TANH:           res_wide_s[i] = PW'($signed(s2_t_r[i*DW +: DW]));
        ACT_SWISH, ACT_GELU: res_wide_s[i] = (prod_s[i] + P_ROUND) >>> FRAC_BITS;
        default:            res_wide_s[i] = PW'(x2_s[i]);
      endcase
      if (res_wide_s[i] > P_MAX) begin
        res_s[i*DW +: DW] = DW'(P_MAX);
      end else if (res_wide_s[i] < P_MIN) begin
        res_s[i*DW +: DW] = DW'(P_MIN);
      end else begin
        res_s[i*DW +: DW] = DW'(res_wide_s[i]);
      end
    end
  end

  // Stage registers S1..S3, shifting together on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s3_valid_r <= 1'b0;
      s1_type_r  <= 3'd0;
      s2_type_r  <= 3'd0;
      s1_data_r  <= {LW{1'b0}};
      s2_x_r     <= {LW{1'b0}};
      s2_g_r     <= {LW{1'b0}};
      s2_t_r     <= {LW{1'b0}};
      s3_data_r  <= {LW{1'b0}};
    end else if (advance_s) begin
      s1_valid_r <= in_valid;
      s1_type_r  <= in_act_type;
      s1_data_r  <= in_data;
      s2_valid_r <= s1_valid_r;
      s2_type_r  <= s1_type_r;
      s2_x_r     <= s1_data_r;
      s2_g_r     <= gate_s;
      s2_t_r     <= tanh_s;
      s3_valid_r <= s2_valid_r;
      s3_data_r  <= res_s;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

`ifdef ACT_STATS_EN
  logic [LANES-1:0] clip_s, s2_clip_r;
  logic [31:0]      beats_r, clips_r;

  function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < LANES; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // Per-lane clip flags: pre-clamp gate outside [0,1.0], or tanh input outside [-1.0,1.0]
  always_comb begin
    clip_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      case (s1_type_r)
        ACT_GELU, ACT_SWISH, ACT_SIGMOID: clip_s[i] = (g_pre_s[i] < G_ZERO) || (g_pre_s[i] > G_ONE);
        ACT_TANH:                         clip_s[i] = (x_ext_s[i] < G_NEG_ONE) || (x_ext_s[i] > G_ONE);
        default:                          clip_s[i] = 1'b0;
      endcase
    end
  end

  // Statistics counters; clips are counted as a valid beat leaves S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_clip_r <= {LANES{1'b0}};
      beats_r   <= 32'd0;
      clips_r   <= 32'd0;
    end else begin
      if (advance_s) begin
        s2_clip_r <= clip_s;
      end else begin
        s2_clip_r <= s2_clip_r;
      end
      if (s3_valid_r && out_ready) begin
        beats_r <= beats_r + 32'd1;
      end else begin
        beats_r <= beats_r;
      end
      if (s2_valid_r && advance_s) begin
        clips_r <= clips_r + popcount(s2_clip_r);
      end else begin
        clips_r <= clips_r;
      end
    end
  end

  assign stat_beats = beats_r;
  assign stat_clips = clips_r;
`else
  assign stat_beats = 32'd0;
  assign stat_clips = 32'd0;
`endif

endmodule
